product_display_driver: RTL and testbench

- Downstream consumer of the 3-bit sign-magnitude multiplier.
- Captures the 5-bit product (bit 4 = sign, bits 3:0 = magnitude) and the zero flag through a valid/ready handshake.
- Converts the magnitude to two decimal digits with an iterative subtractor.
- Drives a time-multiplexed 3-digit seven-segment display: sign, tens, units.

---
 rtl/product_display_driver_pkg.sv | 26 ++
 rtl/product_display_driver_seg7_decode.sv | 22 ++
 rtl/product_display_driver.sv | 158 +++++++++++++++
 tb/tb_product_display_driver.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/product_display_driver_pkg.sv
// Shared definitions for the product display driver.
//   - state_e    : controller states (IDLE, CONV, SHOW)
//   - SEG_DIGIT  : active-high seven-segment codes for 0..9 (bit 0 = a, bit 6 = g)
//   - SEG_MINUS / SEG_BLANK : sign-digit and blank codes
//   - DIG_*      : scan index of each display digit
package product_display_driver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_e;

  localparam logic [0:9][6:0] SEG_DIGIT = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DIG_UNITS = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_SIGN  = 2'd2;

endpackage

// File: rtl/product_display_driver_seg7_decode.sv
// Combinational BCD to seven-segment decoder.
//   digit [3:0] : decimal digit 0..9 (codes above 9 decode to blank)
//   blank       : force all segments off
//   seg   [6:0] : active-high segments, seg[0]=a .. seg[6]=g
module seg7_decode
  import product_display_driver_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      for (int unsigned i = 0; i < 10; i++) begin
        if (digit == 4'(i)) seg = SEG_DIGIT[i];
      end
    end
  end

endmodule

// File: rtl/product_display_driver.sv
// Captures a 5-bit sign-magnitude product plus zero flag over valid/ready,
// converts the magnitude to tens/units by repeated subtraction of 10, and
// scans the result onto a 3-digit multiplexed seven-segment display.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/in_ready : capture handshake (ready whenever not converting)
//   product [4:0] : bit 4 sign (1 = negative), bits 3:0 magnitude
//   zero_flag     : captured with product, shown on zero_led after conversion
//   seg [6:0]     : active-high segments, seg[0]=a .. seg[6]=g
//   an  [2:0]     : one-hot digit select, an[0]=units, an[1]=tens, an[2]=sign
//   zero_led      : zero flag of the displayed value
//   disp_valid    : a conversion has completed since reset
// Optional macro NEG_ZERO_SUPPRESS_EN: blank the sign digit when the
// displayed magnitude is zero.
module product_display_driver
  import product_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] product,
  input  logic       zero_flag,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       zero_led,
  output logic       disp_valid
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_e        state_q, state_d;
  logic          sign_w_q, sign_w_d;
  logic [3:0]    mag_w_q, mag_w_d;
  logic          tens_w_q, tens_w_d;     // tens of a 0..15 value is 0 or 1
  logic          zero_w_q, zero_w_d;
  logic          disp_sign_q, disp_sign_d;
  logic          disp_tens_q, disp_tens_d;
  logic [3:0]    disp_units_q, disp_units_d;
  logic          zero_led_q, zero_led_d;
  logic          disp_valid_q, disp_valid_d;
  logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    scan_idx_q, scan_idx_d;

  logic [3:0] dec_digit;
  logic       dec_blank;
  logic [6:0] dec_seg;
  logic       sign_on;

  always_comb begin
    state_d       = state_q;
    sign_w_d      = sign_w_q;
    mag_w_d       = mag_w_q;
    tens_w_d      = tens_w_q;
    zero_w_d      = zero_w_q;
    disp_sign_d   = disp_sign_q;
    disp_tens_d   = disp_tens_q;
    disp_units_d  = disp_units_q;
    zero_led_d    = zero_led_q;
    disp_valid_d  = disp_valid_q;

    case (state_q)
      IDLE, SHOW: begin
        if (in_valid) begin
          sign_w_d = product[4];
          mag_w_d  = product[3:0];
          zero_w_d = zero_flag;
          tens_w_d = 1'b0;
          state_d  = CONV;
        end
      end
      CONV: begin
        if (mag_w_q >= 4'd10) begin
          mag_w_d  = mag_w_q - 4'd10;
          tens_w_d = 1'b1;
        end else begin
          // Display registers load only here, so partial results never show.
          disp_sign_d  = sign_w_q;
          disp_tens_d  = tens_w_q;
          disp_units_d = mag_w_q;
          zero_led_d   = zero_w_q;
          disp_valid_d = 1'b1;
          state_d      = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase

    if (refresh_cnt_q == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt_d = '0;
      scan_idx_d    = (scan_idx_q == DIG_SIGN) ? DIG_UNITS : scan_idx_q + 2'd1;
    end else begin
      refresh_cnt_d = refresh_cnt_q + CW'(1);
      scan_idx_d    = scan_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sign_w_q      <= '0;
      mag_w_q       <= '0;
      tens_w_q      <= '0;
      zero_w_q      <= '0;
      disp_sign_q   <= '0;
      disp_tens_q   <= '0;
      disp_units_q  <= '0;
      zero_led_q    <= '0;
      disp_valid_q  <= '0;
      refresh_cnt_q <= '0;
      scan_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      sign_w_q      <= sign_w_d;
      mag_w_q       <= mag_w_d;
      tens_w_q      <= tens_w_d;
      zero_w_q      <= zero_w_d;
      disp_sign_q   <= disp_sign_d;
      disp_tens_q   <= disp_tens_d;
      disp_units_q  <= disp_units_d;
      zero_led_q    <= zero_led_d;
      disp_valid_q  <= disp_valid_d;
      refresh_cnt_q <= refresh_cnt_d;
      scan_idx_q    <= scan_idx_d;
    end
  end

  always_comb begin
    dec_digit = (scan_idx_q == DIG_TENS) ? {3'b000, disp_tens_q} : disp_units_q;
    // Leading-zero suppression on the tens digit.
    dec_blank = !disp_valid_q || ((scan_idx_q == DIG_TENS) && !disp_tens_q);
    sign_on   = disp_valid_q && disp_sign_q;
`ifdef NEG_ZERO_SUPPRESS_EN
    sign_on   = sign_on && (disp_tens_q || (disp_units_q != 4'd0));
`endif
  end

  seg7_decode u_seg7_decode (
    .digit (dec_digit),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  always_comb begin
    case (scan_idx_q)
      DIG_UNITS, DIG_TENS: seg = dec_seg;
      DIG_SIGN:            seg = sign_on ? SEG_MINUS : SEG_BLANK;
      default:             seg = SEG_BLANK;
    endcase
  end

  assign an         = 3'b001 << scan_idx_q;
  assign in_ready   = (state_q != CONV);
  assign zero_led   = zero_led_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_product_display_driver.sv
// Self-checking bench for product_display_driver with REFRESH_DIV=4.
// Expected display contents come from decimal arithmetic on the captured
// product; expected conversion time comes from the magnitude range.
module tb_product_display_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] product;
  logic       zero_flag;
  logic [6:0] seg;
  logic [2:0] an;
  logic       zero_led;
  logic       disp_valid;

  int errors = 0;
  int checks = 0;

  // Model of the last value shown (for checks while converting).
  logic prev_zero  = 1'b0;
  logic prev_valid = 1'b0;

  product_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .product    (product),
    .zero_flag  (zero_flag),
    .seg        (seg),
    .an         (an),
    .zero_led   (zero_led),
    .disp_valid (disp_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_sign_code(input logic neg, input int mag);
`ifdef NEG_ZERO_SUPPRESS_EN
    if (mag == 0) return 7'h00;
`endif
    return neg ? 7'h40 : 7'h00;
  endfunction

  // Scan one full refresh frame and collect each digit's segments by its anode.
  task automatic read_display(output logic [6:0] s_sign, output logic [6:0] s_tens,
                              output logic [6:0] s_units);
    s_sign = 'x; s_tens = 'x; s_units = 'x;
    repeat (3 * DIV) begin
      checks++;
      case (an)
        3'b001: s_units = seg;
        3'b010: s_tens  = seg;
        3'b100: s_sign  = seg;
        default: begin
          errors++;
          $display("FAIL an_onehot: got %b, required one-hot", an);
        end
      endcase
      tick();
    end
  endtask

  task automatic check_display(input string name, input logic [4:0] p, input logic z);
    logic [6:0] s_sign, s_tens, s_units, e_sign, e_tens, e_units;
    int mag;
    mag     = int'(p[3:0]);
    e_sign  = exp_sign_code(p[4], mag);
    e_tens  = (mag >= 10) ? digit_code(mag / 10) : 7'h00;
    e_units = digit_code(mag % 10);
    read_display(s_sign, s_tens, s_units);
    checks += 5;
    if (s_sign !== e_sign) begin
      errors++; $display("FAIL %s sign: got %h, required %h", name, s_sign, e_sign);
    end
    if (s_tens !== e_tens) begin
      errors++; $display("FAIL %s tens: got %h, required %h", name, s_tens, e_tens);
    end
    if (s_units !== e_units) begin
      errors++; $display("FAIL %s units: got %h, required %h", name, s_units, e_units);
    end
    if (zero_led !== z) begin
      errors++; $display("FAIL %s zero_led: got %b, required %b", name, zero_led, z);
    end
    if (disp_valid !== 1'b1) begin
      errors++; $display("FAIL %s disp_valid: got %b, required 1", name, disp_valid);
    end
  endtask

  // Capture one product (block assumed ready) and measure busy cycles.
  task automatic capture(input string name, input logic [4:0] p, input logic z);
    int busy, exp_busy;
    exp_busy  = (p[3:0] >= 4'd10) ? 2 : 1;
    in_valid  = 1'b1;
    product   = p;
    zero_flag = z;
    tick();
    in_valid  = 1'b0;
    busy = 0;
    while (!in_ready && busy < 8) begin
      checks += 2;
      if (zero_led !== prev_zero) begin
        errors++; $display("FAIL %s held_zero_led: got %b, required %b", name, zero_led, prev_zero);
      end
      if (disp_valid !== prev_valid) begin
        errors++; $display("FAIL %s held_disp_valid: got %b, required %b", name, disp_valid, prev_valid);
      end
      busy++;
      tick();
    end
    checks++;
    if (busy !== exp_busy) begin
      errors++; $display("FAIL %s conv_cycles: got %0d, required %0d", name, busy, exp_busy);
    end
    prev_zero  = z;
    prev_valid = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    checks += 5;
    if (an !== 3'b001) begin errors++; $display("FAIL %s an: got %b, required 001", name, an); end
    if (seg !== 7'h00) begin errors++; $display("FAIL %s seg: got %h, required 00", name, seg); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b, required 1", name, in_ready); end
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL %s disp_valid: got %b, required 0", name, disp_valid); end
    if (zero_led !== 1'b0) begin errors++; $display("FAIL %s zero_led: got %b, required 0", name, zero_led); end
  endtask

  task automatic test_reset();
    logic [2:0] exp_an;
    rst = 1'b1; in_valid = 1'b0; product = '0; zero_flag = 1'b0;
    tick(); tick();
    rst = 1'b0;
    prev_zero = 1'b0; prev_valid = 1'b0;
    check_reset_outputs("reset");
    for (int k = 0; k < 13; k++) begin
      exp_an = 3'b001 << ((k / DIV) % 3);
      checks += 2;
      if (an !== exp_an) begin
        errors++; $display("FAIL reset_scan k=%0d an: got %b, required %b", k, an, exp_an);
      end
      if (seg !== 7'h00) begin
        errors++; $display("FAIL reset_scan k=%0d seg: got %h, required 00", k, seg);
      end
      tick();
    end
  endtask

  task automatic test_neg6();
    capture("neg6", 5'b10110, 1'b0);
    check_display("neg6", 5'b10110, 1'b0);
  endtask

  task automatic test_pos12();
    capture("pos12", 5'b01100, 1'b0);
    check_display("pos12", 5'b01100, 1'b0);
  endtask

  task automatic test_ignore_in_conv();
    in_valid = 1'b1; product = 5'b01100; zero_flag = 1'b0;
    tick();
    product = 5'b00011; zero_flag = 1'b1;   // offered while busy
    tick();
    in_valid = 1'b0;
    tick();
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ignore in_ready: got %b, required 1", in_ready); end
    tick();
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ignore no_requeue: got %b, required 1", in_ready); end
    prev_zero = 1'b0; prev_valid = 1'b1;
    check_display("ignore", 5'b01100, 1'b0);
  endtask

  task automatic test_neg_zero();
    capture("negzero", 5'b10000, 1'b1);
    check_display("negzero", 5'b10000, 1'b1);
  endtask

  task automatic test_random();
    logic [4:0] p;
    logic z;
    for (int i = 0; i < 30; i++) begin
      p = 5'($urandom_range(0, 31));
      z = (p[3:0] == 4'd0) ? 1'b1 : 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
      capture($sformatf("rand%0d", i), p, z);
      check_display($sformatf("rand%0d", i), p, z);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ps [4] = '{5'b01111, 5'b10011, 5'b11010, 5'b00101};
    logic       zs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int busy, exp_busy;
    in_valid = 1'b1; product = ps[0]; zero_flag = zs[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_busy = (ps[i][3:0] >= 4'd10) ? 2 : 1;
      busy = 0;
      while (!in_ready && busy < 8) begin busy++; tick(); end
      checks += 2;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL b2b%0d conv_cycles: got %0d, required %0d", i, busy, exp_busy);
      end
      if (zero_led !== zs[i]) begin
        errors++; $display("FAIL b2b%0d zero_led: got %b, required %b", i, zero_led, zs[i]);
      end
      if (i < 3) begin
        product = ps[i+1]; zero_flag = zs[i+1];
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    prev_zero = zs[3]; prev_valid = 1'b1;
    check_display("b2b_last", ps[3], zs[3]);
  endtask

  task automatic test_reset_mid_conv();
    in_valid = 1'b1; product = 5'b01111; zero_flag = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b, required 0", in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_zero = 1'b0; prev_valid = 1'b0;
    check_reset_outputs("rst_mid");
    tick(); tick();
    checks++;
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid aborted: got %b, required 0", disp_valid); end
  endtask

  task automatic test_reset_with_valid();
    rst = 1'b1; in_valid = 1'b1; product = 5'b00101; zero_flag = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_reset_outputs("rst_valid");
    tick(); tick(); tick();
    checks += 2;
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid no_capture: got %b, required 0", disp_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_valid idle: got %b, required 1", in_ready); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; product = '0; zero_flag = 1'b0;
    test_reset();
    test_neg6();
    test_pos12();
    test_ignore_in_conv();
    test_neg_zero();
    test_random();
    test_back_to_back();
    test_reset_mid_conv();
    test_reset_with_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
